// File: rtl/uart_tx_ctrl_if.sv
// AXI4-Lite bus bundle used by the UART transmit controller.
// The controller is the master; the UART register block (or a bench model)
// is the slave. 32-bit address and 32-bit data.
interface uart_tx_ctrl_if;
  // Write address channel
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  // Write data channel
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  // Write response channel
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  // Read address channel
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  // Read data channel
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );

  modport slave (
    input  awvalid, awaddr,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: buffers bytes from a CPU-side producer and
// writes them one at a time into a UART TX FIFO register over AXI4-Lite.
// Optionally polls the UART status register (bit 3 = TX full) before each
// write. Exactly one AXI transaction is in flight at any time.
module uart_tx_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 8,
  parameter bit          POLL_STATUS = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     in_data,
  uart_tx_ctrl_if.master m_axilite,
  output logic           busy,
  output logic           err
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] TX_ADDR   = BASE_ADDR + 32'h0000_0004;
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'h0000_0008;
  localparam int          TX_FULL_BIT = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POLL_AR = 3'd1,
    POLL_R  = 3'd2,
    WR      = 3'd3,
    WR_B    = 3'd4
  } state_t;

  // First state of a byte transfer: status poll or direct write.
  localparam state_t FIRST_ST = POLL_STATUS ? POLL_AR : WR;

  // ---------------------------------------------------------------------
  // Byte buffer
  // ---------------------------------------------------------------------
  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        more_after_pop;
  logic [7:0]  head_byte;

  // ---------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------
  state_t state_q, state_d;
  logic   aw_pend_q, aw_pend_d;
  logic   w_pend_q, w_pend_d;
  logic   err_q, err_d;

  // Handshake qualifiers
  logic aw_vld, w_vld, ar_vld, r_rdy, b_rdy;
  logic aw_hs, w_hs, ar_hs, r_hs, b_hs;

  // rdata bits other than the TX-full flag carry nothing we act on.
  logic unused_rdata;
  assign unused_rdata = ^{m_axilite.rdata[31:TX_FULL_BIT+1],
                          m_axilite.rdata[TX_FULL_BIT-1:0]};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign pop       = (state_q == WR_B) && m_axilite.bvalid && !empty;
  assign head_byte = mem_q[rd_ptr_q[AW-1:0]];

  // Channel valid/ready outputs decode directly from the FSM state.
  assign ar_vld = (state_q == POLL_AR);
  assign r_rdy  = (state_q == POLL_R);
  assign aw_vld = (state_q == WR) && aw_pend_q;
  assign w_vld  = (state_q == WR) && w_pend_q;
  assign b_rdy  = (state_q == WR_B);

  assign aw_hs = aw_vld && m_axilite.awready;
  assign w_hs  = w_vld  && m_axilite.wready;
  assign ar_hs = ar_vld && m_axilite.arready;
  assign r_hs  = r_rdy  && m_axilite.rvalid;
  assign b_hs  = b_rdy  && m_axilite.bvalid;

  assign m_axilite.arvalid = ar_vld;
  assign m_axilite.araddr  = STAT_ADDR;
  assign m_axilite.rready  = r_rdy;
  assign m_axilite.awvalid = aw_vld;
  assign m_axilite.awaddr  = TX_ADDR;
  assign m_axilite.wvalid  = w_vld;
  assign m_axilite.wdata   = {24'h00_0000, head_byte};
  assign m_axilite.wstrb   = 4'b0001;
  assign m_axilite.bready  = b_rdy;

  assign busy = (state_q != IDLE) || !empty;
  assign err  = err_q;

  // Next buffer pointers from this cycle's push and pop.
  always_comb begin
    wr_ptr_d       = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d       = rd_ptr_q + {{AW{1'b0}}, pop};
    more_after_pop = (wr_ptr_d != rd_ptr_d);
  end

  // Buffer pointer registers; reset discards any buffered bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Byte storage; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

  // Transfer sequencing: poll status, issue write, wait for response.
  always_comb begin
    state_d   = state_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = FIRST_ST;
        end
      end
      POLL_AR: begin
        if (ar_hs) begin
          state_d = POLL_R;
        end
      end
      POLL_R: begin
        if (r_hs) begin
          state_d = m_axilite.rdata[TX_FULL_BIT] ? POLL_AR : WR;
        end
      end
      WR: begin
        // Address and data channels retire independently.
        aw_pend_d = aw_pend_q && !aw_hs;
        w_pend_d  = w_pend_q && !w_hs;
        if (!aw_pend_d && !w_pend_d) begin
          state_d = WR_B;
        end
      end
      WR_B: begin
        // The byte is consumed whatever bresp says; there is no retry.
        if (b_hs) begin
          state_d = more_after_pop ? FIRST_ST : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Both write channels go valid together on every entry into WR.
    if ((state_d == WR) && (state_q != WR)) begin
      aw_pend_d = 1'b1;
      w_pend_d  = 1'b1;
    end
  end

  // Sticky error on any non-OKAY write or read response.
  always_comb begin
    err_d = err_q;
    if (b_hs && (m_axilite.bresp != 2'b00)) begin
      err_d = 1'b1;
    end
    if (r_hs && (m_axilite.rresp != 2'b00)) begin
      err_d = 1'b1;
    end
  end

  // Control registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl. Instance u[0] writes directly, u[1]
// polls status first. Each instance has a small AXI4-Lite slave model that
// logs addresses/data; the stimulus sequence below checks the logs.
module tb_uart_tx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] in_vld;
  logic [1:0] in_rdy;
  logic [1:0] busy;
  logic [1:0] err;
  logic [1:0] awr_en;
  logic [1:0] wr_en;
  logic [1:0] ar_en;
  logic [7:0] in_dat [2];
  logic [1:0] bresp_k [2];
  logic [31:0] stat_tab [0:7];

  int ncmp = 0;
  int nerr = 0;

  for (genvar g = 0; g < 2; g++) begin : u
    uart_tx_ctrl_if bus ();

    uart_tx_ctrl #(
      .BASE_ADDR  (32'h0000_0000),
      .DEPTH      (8),
      .POLL_STATUS(g == 1)
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_vld[g]),
      .in_ready (in_rdy[g]),
      .in_data  (in_dat[g]),
      .m_axilite(bus.master),
      .busy     (busy[g]),
      .err      (err[g])
    );

    logic        bv  = 1'b0;
    logic        rv  = 1'b0;
    logic [1:0]  br  = 2'b00;
    logic [31:0] rd  = 32'h0;
    logic        awd = 1'b0;
    logic        wdn = 1'b0;
    int awc = 0, wc = 0, rac = 0, rcnt = 0, bcnt = 0, ovl = 0;
    logic [31:0] wa  [0:31];
    logic [31:0] wd  [0:31];
    logic [3:0]  ws  [0:31];
    int          wrd [0:31];
    logic [31:0] ra  [0:31];
    logic aw_hs, w_hs;

    assign bus.awready = awr_en[g];
    assign bus.wready  = wr_en[g];
    assign bus.arready = ar_en[g];
    assign bus.bvalid  = bv;
    assign bus.bresp   = br;
    assign bus.rvalid  = rv;
    assign bus.rdata   = rd;
    assign bus.rresp   = 2'b00;
    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid && bus.wready;

    always @(posedge clk) begin
      if (bus.awvalid && bus.arvalid) ovl <= ovl + 1;
      if (aw_hs) begin
        wa[awc[4:0]]  <= bus.awaddr;
        wrd[awc[4:0]] <= rcnt;
        awc <= awc + 1;
      end
      if (w_hs) begin
        wd[wc[4:0]] <= bus.wdata;
        ws[wc[4:0]] <= bus.wstrb;
        wc <= wc + 1;
      end
      if (bus.arvalid && bus.arready) begin
        ra[rac[4:0]] <= bus.araddr;
        rac <= rac + 1;
      end
      if (bus.rvalid && bus.rready) rcnt <= rcnt + 1;
      if (bus.bvalid && bus.bready) bcnt <= bcnt + 1;
      if (!rst_n) begin
        bv  <= 1'b0;
        rv  <= 1'b0;
        awd <= 1'b0;
        wdn <= 1'b0;
      end else begin
        if (bv && bus.bready) bv <= 1'b0;
        if (rv && bus.rready) rv <= 1'b0;
        if (bus.arvalid && bus.arready) begin
          rv <= 1'b1;
          rd <= stat_tab[rac[2:0]];
        end
        if ((awd || aw_hs) && (wdn || w_hs)) begin
          bv  <= 1'b1;
          br  <= bresp_k[g];
          awd <= 1'b0;
          wdn <= 1'b0;
        end else begin
          awd <= awd || aw_hs;
          wdn <= wdn || w_hs;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int g, input logic [7:0] b);
    in_vld[g] = 1'b1;
    in_dat[g] = b;
    for (int k = 0; k < 200 && !in_rdy[g]; k++) tick();
    chk1("push_ready", in_rdy[g], 1'b1);
    tick();
    in_vld[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g, input string tag);
    for (int k = 0; k < 400 && busy[g]; k++) tick();
    chk1(tag, busy[g], 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bw, ba, bb, bra;
    rst_n      = 1'b0;
    in_vld     = 2'b00;
    in_dat[0]  = 8'h00;
    in_dat[1]  = 8'h00;
    awr_en     = 2'b11;
    wr_en      = 2'b11;
    ar_en      = 2'b11;
    bresp_k[0] = 2'b00;
    bresp_k[1] = 2'b00;
    for (int i = 0; i < 8; i++) stat_tab[i] = (i < 3) ? 32'h8 : 32'h0;

    // Reset state
    tick();
    tick();
    chk1("rst_busy", busy[0], 1'b0);
    chk1("rst_in_ready", in_rdy[0], 1'b1);
    chk1("rst_awvalid", u[0].bus.awvalid, 1'b0);
    chk1("rst_arvalid", u[1].bus.arvalid, 1'b0);
    chk1("rst_err", err[0], 1'b0);
    rst_n = 1'b1;
    tick();
    chk1("rel_awvalid", u[0].bus.awvalid, 1'b0);
    chk1("rel_busy", busy[1], 1'b0);

    // Direct write of two back-to-back bytes, minimum latency
    bw = u[0].wc;
    bb = u[0].bcnt;
    in_vld[0] = 1'b1;
    in_dat[0] = 8'h48;
    tick();
    chk1("lat_aw_early", u[0].bus.awvalid, 1'b0);
    chk1("lat_busy", busy[0], 1'b1);
    in_dat[0] = 8'h69;
    tick();
    in_vld[0] = 1'b0;
    chk1("lat_awvalid", u[0].bus.awvalid, 1'b1);
    chk1("lat_wvalid", u[0].bus.wvalid, 1'b1);
    chk32("lat_awaddr", u[0].bus.awaddr, 32'h4);
    chk32("lat_wdata", u[0].bus.wdata, 32'h48);
    chk32("lat_wstrb", {28'h0, u[0].bus.wstrb}, 32'h1);
    wait_idle(0, "two_idle");
    chk32("two_bcnt", u[0].bcnt - bb, 32'd2);
    chk32("two_wcnt", u[0].wc - bw, 32'd2);
    chk32("two_wd0", u[0].wd[bw], 32'h48);
    chk32("two_wd1", u[0].wd[bw + 1], 32'h69);
    chk32("two_wa0", u[0].wa[bw], 32'h4);
    chk32("two_wa1", u[0].wa[bw + 1], 32'h4);
    chk32("two_ws1", {28'h0, u[0].ws[bw + 1]}, 32'h1);
    chk1("two_err", err[0], 1'b0);

    // Status polling: TX full three times, then clear
    bra = u[1].rac;
    ba  = u[1].awc;
    push(1, 8'h5A);
    wait_idle(1, "poll_idle");
    chk32("poll_reads", u[1].rac - bra, 32'd4);
    for (int i = 0; i < 4; i++) chk32("poll_araddr", u[1].ra[bra + i], 32'h8);
    chk32("poll_writes", u[1].awc - ba, 32'd1);
    chk32("poll_reads_before_wr", u[1].wrd[ba], 32'd4);
    chk32("poll_wdata", u[1].wd[ba], 32'h5A);
    chk32("poll_awaddr", u[1].wa[ba], 32'h4);

    // awready held off 3 cycles after the data handshake
    bw = u[0].wc;
    ba = u[0].awc;
    bb = u[0].bcnt;
    awr_en[0] = 1'b0;
    push(0, 8'h11);
    for (int k = 0; k < 50 && u[0].wc == bw; k++) tick();
    chk32("split_w_fired", u[0].wc - bw, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk1("split_wvalid_low", u[0].bus.wvalid, 1'b0);
      chk1("split_awvalid_held", u[0].bus.awvalid, 1'b1);
      chk32("split_awaddr", u[0].bus.awaddr, 32'h4);
      tick();
    end
    awr_en[0] = 1'b1;
    wait_idle(0, "split_idle");
    chk32("split_bcnt", u[0].bcnt - bb, 32'd1);
    chk32("split_awcnt", u[0].awc - ba, 32'd1);
    chk32("split_wdata", u[0].wd[bw], 32'h11);

    // Fill the buffer against a stalled slave
    bw = u[0].wc;
    bb = u[0].bcnt;
    awr_en[0] = 1'b0;
    wr_en[0]  = 1'b0;
    for (int i = 1; i <= 8; i++) push(0, 8'(i));
    chk1("full_in_ready", in_rdy[0], 1'b0);
    in_vld[0] = 1'b1;
    in_dat[0] = 8'h09;
    tick();
    tick();
    tick();
    chk1("full_still_blocked", in_rdy[0], 1'b0);
    chk32("full_no_b", u[0].bcnt - bb, 32'd0);
    awr_en[0] = 1'b1;
    wr_en[0]  = 1'b1;
    for (int k = 0; k < 50 && !in_rdy[0]; k++) tick();
    chk1("full_reopen", in_rdy[0], 1'b1);
    chk32("full_reopen_after_b", u[0].bcnt - bb, 32'd1);
    tick();
    in_vld[0] = 1'b0;
    wait_idle(0, "full_idle");
    for (int i = 0; i < 9; i++) chk32("full_order", u[0].wd[bw + i], 32'(i + 1));
    chk32("full_bcnt", u[0].bcnt - bb, 32'd9);

    // SLVERR on the first write: sticky err, no retry
    bw = u[0].wc;
    bb = u[0].bcnt;
    bresp_k[0] = 2'b10;
    push(0, 8'hA1);
    push(0, 8'hA2);
    push(0, 8'hA3);
    for (int k = 0; k < 50 && u[0].bcnt == bb; k++) tick();
    bresp_k[0] = 2'b00;
    chk1("err_set", err[0], 1'b1);
    wait_idle(0, "err_idle");
    chk1("err_sticky", err[0], 1'b1);
    chk32("err_wd0", u[0].wd[bw], 32'hA1);
    chk32("err_wd1", u[0].wd[bw + 1], 32'hA2);
    chk32("err_wd2", u[0].wd[bw + 2], 32'hA3);
    chk32("err_bcnt", u[0].bcnt - bb, 32'd3);

    // Reset during a stalled write with three bytes buffered
    awr_en[0] = 1'b0;
    wr_en[0]  = 1'b0;
    push(0, 8'hB1);
    push(0, 8'hB2);
    push(0, 8'hB3);
    tick();
    chk1("mid_awvalid", u[0].bus.awvalid, 1'b1);
    chk1("mid_busy", busy[0], 1'b1);
    bw = u[0].wc;
    ba = u[0].awc;
    bb = u[0].bcnt;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk1("mrst_awvalid", u[0].bus.awvalid, 1'b0);
    chk1("mrst_wvalid", u[0].bus.wvalid, 1'b0);
    chk1("mrst_arvalid", u[0].bus.arvalid, 1'b0);
    chk1("mrst_busy", busy[0], 1'b0);
    chk1("mrst_in_ready", in_rdy[0], 1'b1);
    chk1("mrst_err", err[0], 1'b0);
    awr_en[0] = 1'b1;
    wr_en[0]  = 1'b1;
    tick();
    chk1("mrst_first_cycle", u[0].bus.awvalid, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk32("mrst_no_aw", u[0].awc - ba, 32'd0);
    chk32("mrst_no_w", u[0].wc - bw, 32'd0);
    chk32("mrst_no_b", u[0].bcnt - bb, 32'd0);
    chk1("mrst_idle", busy[0], 1'b0);

    // ar and aw never overlapped on either instance
    chk32("no_overlap0", u[0].ovl, 32'd0);
    chk32("no_overlap1", u[1].ovl, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0000: UART register base; TX FIFO at BASE_ADDR+0x004, status at BASE_ADDR+0x008.
REQ-002 Parameter DEPTH, 8: byte-buffer entries; SHALL be a power of two, 2..64.
REQ-003 Parameter POLL_STATUS, 1: 1 = read status before every write; 0 = write directly.
REQ-004 The clock and reset are decided: one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 in_valid / in_ready / in_data  input / output / input  1/1/8  byte stream from the CPU-side producer.
REQ-008 m_axilite_aw{valid,ready,addr}, w{valid,ready,data,strb}, b{valid,ready,resp}, ar{valid,ready,addr}, r{valid,ready,data,resp}  AXI4-Lite master, 32-bit address, 32-bit data.
REQ-009 busy  output  1  high when the FSM is not IDLE or the buffer is non-empty.
REQ-010 err  output  1  sticky; set on any non-zero bresp or rresp.

Function
REQ-011 Buffer: DEPTH-entry FIFO; in_ready = !full; push on in_valid&&in_ready; a byte pushed at edge t is visible as non-empty after edge t.
REQ-012 Pointers SHALL be log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full = MSBs differ and low bits equal; empty = pointers equal.
REQ-013 Simultaneous push and pop when full SHALL NOT be allowed (in_ready low); when empty, pop cannot occur; otherwise both proceed and count is unchanged.
REQ-014 FSM states: IDLE, POLL_AR, POLL_R, WR, WR_B.
REQ-015 IDLE -> POLL_AR (POLL_STATUS=1) or WR (POLL_STATUS=0) on the edge where the buffer is non-empty.
REQ-016 POLL_AR: arvalid=1, araddr=BASE_ADDR+0x008; -> POLL_R on arvalid&&arready.
REQ-017 POLL_R: rready=1; on rvalid: if rdata[3] (TX full) = 1 -> POLL_AR, else -> WR.
REQ-018 WR: awaddr=BASE_ADDR+0x004, wdata={24'h0, head byte}, wstrb=4'b0001; awvalid and wvalid asserted together on entry; each deasserts independently after its own handshake; -> WR_B once both have fired (same or different cycles).
REQ-019 WR_B: bready=1; on bvalid -> pop head byte, then -> POLL_AR/WR if the buffer still holds data after the pop, else IDLE.
REQ-020 Exactly one AXI transaction outstanding; ar and aw never asserted in the same cycle.
REQ-021 Head byte and addresses SHALL remain stable while their valid is high.
REQ-022 Bytes SHALL be written in push order, each exactly once, including when bresp is non-zero (no retry).
REQ-023 err sets on bvalid&&bready with bresp!=0 or rvalid&&rready with rresp!=0; cleared only by reset.
REQ-024 Minimum latency (all slaves ready, POLL_STATUS=0): push at edge t -> awvalid high in cycle after edge t+1.

Reset
REQ-025 While rst_n=0 at a rising edge: FSM=IDLE, pointers=0, err=0.
REQ-026 Reset values: all *valid=0, bready=0, rready=0, in_ready=1 after reset, busy=0; addr/data outputs don't-care.
REQ-027 Reset mid-transaction SHALL abandon it and discard buffered bytes; no valid asserted on the first cycle after reset.

Verification
REQ-028 POLL_STATUS=0, slave always ready: push 0x48,0x69 back-to-back -> two writes to 0x004 with wdata 0x48 then 0x69, wstrb 0001, busy falls after the second bvalid.
REQ-029 POLL_STATUS=1, status returns 0x08 three times then 0x00 -> four reads of 0x008, then one write; no write issued before the 0x00 read.
REQ-030 awready delayed 3 cycles after wready fires -> wvalid drops after its handshake, awvalid held with stable awaddr, single bvalid accepted, one byte popped.
REQ-031 Push 9 bytes with slave stalled (DEPTH=8) -> in_ready low after 8th push; 9th byte accepted only after first bvalid; output order 1..9.
REQ-032 bresp=2'b10 on first write -> err=1 and stays 1; following bytes still written in order.
REQ-033 rst_n low for one cycle during WR with 3 bytes buffered -> all valids 0 next cycle, busy=0, in_ready=1, no further AXI traffic.
